pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, PC and address width in bits (>= 8).
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4, return-address stack entries (power of 2, >= 2).
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  hold PC; blocks branch, call and ret effects.
REQ-007 redirect_valid  input  1  absolute redirect (jump or trap).
REQ-008 redirect_target  input  XLEN  absolute redirect address.
REQ-009 branch_taken  input  1  take PC-relative branch.
REQ-010 imm  input  XLEN  two's-complement branch offset.
REQ-011 call  input  1  push pc+4 onto RAS.
REQ-012 ret  input  1  pop RAS top as next PC.
REQ-013 pc  output  XLEN  current PC, registered.
REQ-014 pc_plus4  output  XLEN  pc + 4, combinational, modulo 2^XLEN.
REQ-015 misaligned  output  1  registered one-cycle pulse: last loaded target had bits[1:0] != 0.
REQ-016 ras_empty / ras_full  output  1 each  RAS occupancy flags, registered.
REQ-017 ras_underflow  output  1  registered one-cycle pulse: ret accepted while empty.

Function
REQ-018 Next-PC priority SHALL be: redirect_valid > ret (RAS non-empty) > branch_taken > stall (hold) > pc+4.
REQ-019 redirect_valid SHALL override stall; all other sources SHALL apply only when stall=0.
REQ-020 Branch target SHALL be pc + imm modulo 2^XLEN; negative imm moves backward, with no separate sign input.
REQ-021 Any loaded target SHALL have bits[1:0] forced to 0; misaligned SHALL pulse the next cycle if the unforced bits were nonzero.
REQ-022 Sequential increment SHALL wrap from 2^XLEN-4 to 0 silently.
REQ-023 PC update latency SHALL be one clock: the selected value appears on pc after the next rising edge.
REQ-024 The RAS SHALL be a circular LIFO; call with stall=0 SHALL push pc_plus4.
REQ-025 A push when full SHALL overwrite the oldest entry, keep count at RAS_DEPTH, and keep ras_full=1.
REQ-026 ret with stall=0 and RAS non-empty SHALL load the top entry and decrement the count.
REQ-027 ret with stall=0 and RAS empty SHALL fall through to the branch/sequential choice, pulse ras_underflow, and leave the count at 0.
REQ-028 call and ret together SHALL pop then push: PC takes the old top, the top is replaced by pc_plus4, and the count is unchanged.
REQ-029 When redirect_valid=1, call and ret SHALL be ignored and the RAS left unchanged.

Reset
REQ-030 Reset SHALL asynchronously set pc=RESET_VECTOR and RAS count=0.
REQ-031 Reset SHALL set ras_empty=1, ras_full=0, misaligned=0 and ras_underflow=0.
REQ-032 RAS entry contents SHALL NOT be reset.
REQ-033 Reset asserted mid-operation SHALL discard any pending update in the same cycle.

Configuration
REQ-034 Macro PC_FETCH_RAS_EN SHALL select whether the RAS is built.
REQ-035 With PC_FETCH_RAS_EN defined, the RAS SHALL be built as REQ-024..REQ-029.
REQ-036 Without PC_FETCH_RAS_EN, no RAS storage SHALL exist.
REQ-037 Without PC_FETCH_RAS_EN, call and ret SHALL be ignored, ras_empty tied 1, ras_full and ras_underflow tied 0.

Verification
REQ-038 Release reset with RESET_VECTOR=0x100 and no inputs -> pc 0x100, 0x104, 0x108 on successive edges.
REQ-039 pc=0x200, branch_taken=1, imm=0xFFFFFFF0 -> pc=0x1F0; stall=1 with branch_taken=1 -> pc holds 0x1F0.
REQ-040 stall=1 and redirect_valid=1 with target 0x403 -> pc=0x400 and misaligned pulses one cycle.
REQ-041 Five calls at pc 0x10,0x20,0x30,0x40,0x50, DEPTH=4, then five rets -> PCs 0x54,0x44,0x34,0x24, then ras_underflow pulses and PC goes sequential.
REQ-042 pc=0xFFFFFFFC, no inputs -> pc=0x0.
REQ-043 reset asserted mid-cycle during a call -> pc=RESET_VECTOR immediately and ras_empty=1.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Control/status bundle between a fetch controller and the
//               pc_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            branch_taken;
    logic [XLEN-1:0] imm;
    logic            call;
    logic            ret;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            misaligned;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_underflow;

    modport master (
        output stall, redirect_valid, redirect_target, branch_taken, imm, call, ret,
        input  pc, pc_plus4, misaligned, ras_empty, ras_full, ras_underflow
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, branch_taken, imm, call, ret,
        output pc, pc_plus4, misaligned, ras_empty, ras_full, ras_underflow
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter with redirect/branch/sequential next-PC select
//               and an optional circular return-address stack, built only
//               when the macro PC_FETCH_RAS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  wire logic      clock,
    input  wire logic      reset,
    pc_fetch_unit_if.slave bus
);
    localparam logic [XLEN-1:0] c_FOUR = XLEN'(4);

    logic [XLEN-1:0] r_pc;
    logic            r_misaligned;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_branch_target;
    logic [XLEN-1:0] w_raw_target;
    logic [XLEN-1:0] w_pc_next;
    logic            w_load;
    logic            w_pop;
    logic [XLEN-1:0] w_ras_top;

    assign w_pc_plus4      = r_pc + c_FOUR;
    assign w_branch_target = r_pc + bus.imm;

`ifdef PC_FETCH_RAS_EN
    localparam int                 c_PTR_W = $clog2(RAS_DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH = (c_PTR_W + 1)'(RAS_DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_1 = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_1 = c_PTR_W'(1);

    logic [XLEN-1:0]    r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_ptr_next;
    logic [c_PTR_W-1:0] w_top_idx;
    logic [c_PTR_W-1:0] w_wr_idx;
    logic [c_PTR_W:0]   r_count;
    logic [c_PTR_W:0]   w_count_next;
    logic               r_ras_empty;
    logic               r_ras_full;
    logic               r_underflow;
    logic               w_accept;
    logic               w_push;
    logic               w_ret_miss;

    // r_ptr is the next free slot; the top of stack sits one below it.
    assign w_top_idx  = r_ptr - c_PTR_1;
    assign w_ras_top  = r_ras[w_top_idx];
    assign w_accept   = !bus.redirect_valid && !bus.stall;
    assign w_pop      = w_accept && bus.ret && (r_count != '0);
    assign w_push     = w_accept && bus.call;
    assign w_ret_miss = w_accept && bus.ret && (r_count == '0);
    // A simultaneous pop+push rewrites the top slot in place.
    assign w_wr_idx   = w_pop ? w_top_idx : r_ptr;

    always_comb begin
        w_ptr_next   = r_ptr;
        w_count_next = r_count;
        if (w_pop && !w_push) begin
            w_ptr_next   = w_top_idx;
            w_count_next = r_count - c_CNT_1;
        end else if (w_push && !w_pop) begin
            w_ptr_next = r_ptr + c_PTR_1;
            if (r_count != c_DEPTH) begin
                w_count_next = r_count + c_CNT_1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_ras[w_wr_idx] <= w_pc_plus4;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_ras_empty <= 1'b1;
            r_ras_full  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_next;
            r_count     <= w_count_next;
            r_ras_empty <= (w_count_next == '0);
            r_ras_full  <= (w_count_next == c_DEPTH);
            r_underflow <= w_ret_miss;
        end
    end

    assign bus.ras_empty     = r_ras_empty;
    assign bus.ras_full      = r_ras_full;
    assign bus.ras_underflow = r_underflow;
`else
    logic w_unused_ok;

    assign w_pop             = 1'b0;
    assign w_ras_top         = '0;
    assign w_unused_ok       = &{1'b0, bus.call, bus.ret};
    assign bus.ras_empty     = 1'b1;
    assign bus.ras_full      = 1'b0;
    assign bus.ras_underflow = 1'b0;
`endif

    always_comb begin
        w_load       = 1'b0;
        w_raw_target = w_pc_plus4;
        w_pc_next    = w_pc_plus4;
        if (bus.redirect_valid) begin
            w_load       = 1'b1;
            w_raw_target = bus.redirect_target;
        end else if (w_pop) begin
            w_load       = 1'b1;
            w_raw_target = w_ras_top;
        end else if (!bus.stall && bus.branch_taken) begin
            w_load       = 1'b1;
            w_raw_target = w_branch_target;
        end else if (bus.stall) begin
            w_pc_next = r_pc;
        end
        if (w_load) begin
            w_pc_next = {w_raw_target[XLEN-1:2], 2'b00};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_VECTOR;
            r_misaligned <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_misaligned <= w_load && (w_raw_target[1:0] != 2'b00);
        end
    end

    assign bus.pc         = r_pc;
    assign bus.pc_plus4   = w_pc_plus4;
    assign bus.misaligned = r_misaligned;
endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed-vector bench for pc_fetch_unit; RAS sequences follow
//               the PC_FETCH_RAS_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;
    typedef struct packed {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        br;
        logic [31:0] imm;
        logic        call;
        logic        ret;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    vec_t vecs [16];

    pc_fetch_unit_if #(.XLEN(32)) bus ();

    pc_fetch_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h100),
        .RAS_DEPTH    (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic st, input logic rv, input logic [31:0] tg,
                         input logic br, input logic [31:0] im,
                         input logic cl, input logic rt);
        bus.stall           = st;
        bus.redirect_valid  = rv;
        bus.redirect_target = tg;
        bus.branch_taken    = br;
        bus.imm             = im;
        bus.call            = cl;
        bus.ret             = rt;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //          stall redir tgt           br   imm           call ret  exp_pc        mis
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h104,      1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h108,      1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h200,      1'b0, 32'h0,        1'b0, 1'b0, 32'h200,      1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFF0, 1'b0, 1'b0, 32'h1F0,      1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFFFFF0, 1'b0, 1'b0, 32'h1F0,      1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h403,      1'b0, 32'h0,        1'b0, 1'b0, 32'h400,      1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h404,      1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h6,        1'b0, 1'b0, 32'h408,      1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h408,      1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h1000,     1'b1, 32'h100,      1'b0, 1'b0, 32'h1000,     1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        1'b0, 1'b0, 32'hFFFFFFFC, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h20,       1'b0, 1'b0, 32'h20,       1'b0};
        vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h55,       1'b0, 1'b0, 32'h24,       1'b0};
        vecs[14] = '{1'b0, 1'b1, 32'h7FFFFFFE, 1'b0, 32'h0,        1'b0, 1'b0, 32'h7FFFFFFC, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h7FFFFFFC, 1'b0};

        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("reset_pc",        bus.pc,            32'h100);
        chk("reset_pc_plus4",  bus.pc_plus4,      32'h104);
        chk("reset_ras_empty", {31'b0, bus.ras_empty},     32'h1);
        chk("reset_ras_full",  {31'b0, bus.ras_full},      32'h0);
        chk("reset_mis",       {31'b0, bus.misaligned},    32'h0);
        chk("reset_underflow", {31'b0, bus.ras_underflow}, 32'h0);
        step;
        step;
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].stall, vecs[i].redir, vecs[i].tgt, vecs[i].br,
                  vecs[i].imm, vecs[i].call, vecs[i].ret);
            step;
            chk($sformatf("vec%0d_pc", i),  bus.pc,       vecs[i].exp_pc);
            chk($sformatf("vec%0d_pc4", i), bus.pc_plus4, vecs[i].exp_pc + 32'h4);
            chk($sformatf("vec%0d_mis", i), {31'b0, bus.misaligned}, {31'b0, vecs[i].exp_mis});
        end

        drive(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
        step;
        chk("ras_start_pc", bus.pc, 32'h10);

`ifdef PC_FETCH_RAS_EN
        // Five call+branch steps into a depth-4 stack; the first return address is lost.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 1'b0);
            step;
            chk($sformatf("call%0d_pc", i),    bus.pc, 32'h20 + 32'h10 * i);
            chk($sformatf("call%0d_empty", i), {31'b0, bus.ras_empty}, 32'h0);
            chk($sformatf("call%0d_full", i),  {31'b0, bus.ras_full}, (i >= 3) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            step;
            chk($sformatf("ret%0d_pc", i),    bus.pc, 32'h54 - 32'h10 * i);
            chk($sformatf("ret%0d_full", i),  {31'b0, bus.ras_full}, 32'h0);
            chk($sformatf("ret%0d_empty", i), {31'b0, bus.ras_empty}, (i == 3) ? 32'h1 : 32'h0);
        end
        step;
        chk("underflow_pc",    bus.pc, 32'h28);
        chk("underflow_pulse", {31'b0, bus.ras_underflow}, 32'h1);
        chk("underflow_empty", {31'b0, bus.ras_empty}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step;
        chk("underflow_end_pc", bus.pc, 32'h2C);
        chk("underflow_end",    {31'b0, bus.ras_underflow}, 32'h0);

        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        step;
        chk("push_pc",    bus.pc, 32'h30);
        chk("push_empty", {31'b0, bus.ras_empty}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        step;
        chk("callret_pc",    bus.pc, 32'h30);
        chk("callret_empty", {31'b0, bus.ras_empty}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        step;
        chk("callret_top_pc", bus.pc, 32'h34);
        chk("callret_drain",  {31'b0, bus.ras_empty}, 32'h1);

        drive(1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b1);
        step;
        chk("redir_ignore_pc",    bus.pc, 32'h80);
        chk("redir_ignore_empty", {31'b0, bus.ras_empty}, 32'h1);
        chk("redir_ignore_uf",    {31'b0, bus.ras_underflow}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        step;
        chk("redir_after_pc", bus.pc, 32'h84);
        chk("redir_after_uf", {31'b0, bus.ras_underflow}, 32'h1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        step;
        chk("stall_call_pc",    bus.pc, 32'h84);
        chk("stall_call_empty", {31'b0, bus.ras_empty}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        step;
        chk("pre_rst_pc",    bus.pc, 32'h88);
        chk("pre_rst_empty", {31'b0, bus.ras_empty}, 32'h0);
`else
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 1'b0);
        step;
        chk("noras_call_pc",    bus.pc, 32'h20);
        chk("noras_call_empty", {31'b0, bus.ras_empty}, 32'h1);
        chk("noras_call_full",  {31'b0, bus.ras_full}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        step;
        chk("noras_ret_pc", bus.pc, 32'h24);
        chk("noras_ret_uf", {31'b0, bus.ras_underflow}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        step;
        chk("noras_callret_pc",    bus.pc, 32'h28);
        chk("noras_callret_empty", {31'b0, bus.ras_empty}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
`endif

        // Reset lands between edges while a call is pending.
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_pc",    bus.pc, 32'h100);
        chk("midrst_empty", {31'b0, bus.ras_empty}, 32'h1);
        chk("midrst_full",  {31'b0, bus.ras_full}, 32'h0);
        step;
        chk("midrst_hold_pc", bus.pc, 32'h100);
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step;
        chk("postrst_pc",    bus.pc, 32'h104);
        chk("postrst_empty", {31'b0, bus.ras_empty}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        step;
        chk("postrst_ret_pc", bus.pc, 32'h108);
`ifdef PC_FETCH_RAS_EN
        chk("postrst_ret_uf", {31'b0, bus.ras_underflow}, 32'h1);
`else
        chk("postrst_ret_uf", {31'b0, bus.ras_underflow}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
